// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding, nop word and
// the sequential PC increment.
// The TRAP state only exists when PC_MISALIGN_TRAP_EN is defined.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01
`ifdef PC_MISALIGN_TRAP_EN
    ,
    ST_TRAP  = 2'b10
`endif
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INCR   = 32'h0000_0004;

endpackage

// File: rtl/pc_fetch_stage_ifid_reg.sv
// IF/ID pipeline register. A clear (redirect) squashes the entry to a nop
// and has priority over hold (stall). Hold freezes every field.
module ifid_reg
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        clear,
  input  logic [31:0] instruction,
  input  logic [31:0] pc_plus4,
  output logic [31:0] ifid_instruction,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid
);

  // Capture, squash or hold the fetched instruction and its link address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_instruction <= NOP_INSTR;
      ifid_pc_plus4    <= 32'h0000_0000;
      ifid_valid       <= 1'b0;
    end else if (clear) begin
      ifid_instruction <= NOP_INSTR;
      ifid_pc_plus4    <= ifid_pc_plus4;
      ifid_valid       <= 1'b0;
    end else if (hold) begin
      ifid_instruction <= ifid_instruction;
      ifid_pc_plus4    <= ifid_pc_plus4;
      ifid_valid       <= ifid_valid;
    end else begin
      ifid_instruction <= instruction;
      ifid_pc_plus4    <= pc_plus4;
      ifid_valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_stage.sv
// Program counter and IF/ID register for the five-stage MIPS datapath.
// Redirects (PCSrc) beat stalls; each accepted redirect squashes IF/ID and
// raises FlushOut for FLUSH_SLOTS cycles.
// Optional feature macro: PC_MISALIGN_TRAP_EN -- a misaligned redirect target
// vectors to TRAP_VECTOR and sets the sticky Misalign flag. Without it the
// target's low two bits are forced to zero and Misalign stays low.
module pc_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080,
  parameter int          FLUSH_SLOTS = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Stall,
  input  logic        PCSrc,
  input  logic [31:0] PCNew,
  input  logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        FlushOut,
  output logic        Misalign
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_SLOTS);

  logic [31:0]  pc_r;
  logic [31:0]  pc_plus4_s;
  logic [31:0]  pc_next_s;
  logic [31:0]  redirect_pc_s;
  logic         trap_sel_s;
  logic [2:0]   flush_cnt_r;
  logic [2:0]   flush_cnt_s;
  logic         flush_out_r;
  logic         misalign_r;
  logic         misalign_s;
  fetch_state_e state_r;
  fetch_state_e state_s;
  fetch_state_e resume_state_s;

  assign pc_plus4_s = pc_r + PC_INCR;

  // Pick the redirect target, diverting misaligned targets to the trap vector.
  always_comb begin
    trap_sel_s = 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
    if (PCNew[1:0] != 2'b00) begin
      trap_sel_s = 1'b1;
    end else begin
      trap_sel_s = 1'b0;
    end
`endif
    if (trap_sel_s) begin
      redirect_pc_s = TRAP_VECTOR;
    end else begin
      redirect_pc_s = PCNew & ~32'h0000_0003;
    end
  end

  // Next PC, flush count and misalign flag: redirect > stall > advance.
  always_comb begin
    pc_next_s   = pc_plus4_s;
    flush_cnt_s = flush_cnt_r;
    if (PCSrc) begin
      pc_next_s = redirect_pc_s;
    end else if (Stall) begin
      pc_next_s = pc_r;
    end else begin
      pc_next_s = pc_plus4_s;
    end
    if (PCSrc) begin
      flush_cnt_s = FLUSH_LOAD;
    end else if (flush_cnt_r != 3'd0) begin
      flush_cnt_s = flush_cnt_r - 3'd1;
    end else begin
      flush_cnt_s = flush_cnt_r;
    end
`ifdef PC_MISALIGN_TRAP_EN
    misalign_s = misalign_r | (PCSrc & trap_sel_s);
`else
    misalign_s = 1'b0;
`endif
  end

  // FSM next state: enter FLUSH on a redirect, leave when the count empties.
  always_comb begin
    state_s = state_r;
`ifdef PC_MISALIGN_TRAP_EN
    if (misalign_s) begin
      resume_state_s = ST_TRAP;
    end else begin
      resume_state_s = ST_RUN;
    end
`else
    resume_state_s = ST_RUN;
`endif
    case (state_r)
      ST_FLUSH: begin
        if (PCSrc) begin
          state_s = ST_FLUSH;
        end else if (flush_cnt_s == 3'd0) begin
          state_s = resume_state_s;
        end else begin
          state_s = ST_FLUSH;
        end
      end
      default: begin
        if (PCSrc) begin
          state_s = ST_FLUSH;
        end else begin
          state_s = resume_state_s;
        end
      end
    endcase
  end

  // PC, flush counter, flag and state registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc_r        <= RESET_PC;
      flush_cnt_r <= 3'd0;
      flush_out_r <= 1'b0;
      misalign_r  <= 1'b0;
      state_r     <= ST_RUN;
    end else begin
      pc_r        <= pc_next_s;
      flush_cnt_r <= flush_cnt_s;
      flush_out_r <= (flush_cnt_s != 3'd0);
      misalign_r  <= misalign_s;
      state_r     <= state_s;
    end
  end

  ifid_reg u_ifid_reg (
    .clk              (Clk),
    .rst_n            (Rst),
    .hold             (Stall),
    .clear            (PCSrc),
    .instruction      (Instruction),
    .pc_plus4         (pc_plus4_s),
    .ifid_instruction (IFID_Instruction),
    .ifid_pc_plus4    (IFID_PCPlus4),
    .ifid_valid       (IFID_Valid)
  );

  assign PC       = pc_r;
  assign PCPlus4  = pc_plus4_s;
  assign FlushOut = flush_out_r;
  assign Misalign = misalign_r;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed scenarios followed by
// randomized stall/redirect traffic against a behavioural fetch model.
module tb_pc_fetch_stage;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0080;
  localparam int          FLUSH_SLOTS = 2;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Stall;
  logic        PCSrc;
  logic [31:0] PCNew;
  logic [31:0] Instruction;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic [31:0] IFID_Instruction;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic        FlushOut;
  logic        Misalign;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_ii;
  logic [31:0] m_ip4;
  logic        m_v;
  logic        m_mis;
  int          m_flush;

  always #5 Clk = ~Clk;

  // instruction memory contents as a function of address
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign Instruction = imem(PC);

  pc_fetch_stage #(
    .RESET_PC   (RESET_PC),
    .TRAP_VECTOR(TRAP_VECTOR),
    .FLUSH_SLOTS(FLUSH_SLOTS)
  ) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Stall           (Stall),
    .PCSrc           (PCSrc),
    .PCNew           (PCNew),
    .Instruction     (Instruction),
    .PC              (PC),
    .PCPlus4         (PCPlus4),
    .IFID_Instruction(IFID_Instruction),
    .IFID_PCPlus4    (IFID_PCPlus4),
    .IFID_Valid      (IFID_Valid),
    .FlushOut        (FlushOut),
    .Misalign        (Misalign)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc    = RESET_PC;
    m_ii    = 32'h0000_0000;
    m_ip4   = 32'h0000_0000;
    m_v     = 1'b0;
    m_mis   = 1'b0;
    m_flush = 0;
  endtask

  task automatic check_all();
    check_val("pc",        PC,                 m_pc);
    check_val("pc_plus4",  PCPlus4,            m_pc + 32'd4);
    check_val("ifid_valid", 32'(IFID_Valid),   32'(m_v));
    check_val("ifid_instr", IFID_Instruction,  m_ii);
    if (m_v) check_val("ifid_pc4", IFID_PCPlus4, m_ip4);
    check_val("flush_out", 32'(FlushOut),      32'(m_flush != 0));
    check_val("misalign",  32'(Misalign),      32'(m_mis));
  endtask

  // drive one cycle's inputs (called just after a falling edge), advance the
  // model to the following rising edge, then check at the next falling edge
  task automatic cycle(input logic st, input logic src, input logic [31:0] tgt);
    logic [1:0] lo;
    Stall = st;
    PCSrc = src;
    PCNew = tgt;
    lo    = tgt[1:0];
    if (src) begin
`ifdef PC_MISALIGN_TRAP_EN
      if (lo != 2'b00) begin
        m_pc  = TRAP_VECTOR;
        m_mis = 1'b1;
      end else begin
        m_pc = tgt;
      end
`else
      m_pc = {tgt[31:2], 2'b00};
`endif
      m_v     = 1'b0;
      m_ii    = 32'h0000_0000;
      m_flush = FLUSH_SLOTS;
    end else begin
      if (m_flush > 0) m_flush--;
      if (!st) begin
        m_ii  = imem(m_pc);
        m_ip4 = m_pc + 32'd4;
        m_v   = 1'b1;
        m_pc  = m_pc + 32'd4;
      end
    end
    @(negedge Clk);
    check_all();
  endtask

  initial begin
    logic [31:0] tgt;
    logic        st;
    logic        src;
    Rst   = 1'b0;
    Stall = 1'b0;
    PCSrc = 1'b0;
    PCNew = 32'h0000_0000;
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    check_all();
    Rst = 1'b1;

    // sequential fetch from reset: 4, 8, C, 10
    cycle(1'b0, 1'b0, 32'h0);
    check_val("first_valid", 32'(IFID_Valid), 32'd1);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check_val("seq_pc10", PC, 32'h0000_0010);

    // three stall cycles at 0x10, then resume
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0);
    check_val("stall_hold", PC, 32'h0000_0010);
    cycle(1'b0, 1'b0, 32'h0);
    check_val("stall_resume", PC, 32'h0000_0014);

    // plain redirect and its flush window
    cycle(1'b0, 1'b1, 32'h0000_0040);
    check_val("redir_pc", PC, 32'h0000_0040);
    check_val("redir_squash", 32'(IFID_Valid), 32'd0);
    cycle(1'b0, 1'b0, 32'h0);
    check_val("flush_2nd", 32'(FlushOut), 32'd1);
    cycle(1'b0, 1'b0, 32'h0);
    check_val("flush_done", 32'(FlushOut), 32'd0);

    // redirect together with stall
    cycle(1'b1, 1'b1, 32'h0000_0080);
    check_val("redir_stall_pc", PC, 32'h0000_0080);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);

    // back-to-back redirects
    cycle(1'b0, 1'b1, 32'h0000_0100);
    cycle(1'b0, 1'b1, 32'h0000_0200);
    check_val("b2b_pc", PC, 32'h0000_0200);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);

    // misaligned redirect
    cycle(1'b0, 1'b1, 32'h0000_0043);
`ifdef PC_MISALIGN_TRAP_EN
    check_val("misalign_pc", PC, 32'h0000_0080);
`else
    check_val("misalign_pc", PC, 32'h0000_0040);
`endif
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);

    // PC wrap past the top of the address space
    cycle(1'b0, 1'b1, 32'hFFFF_FFF8);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    check_val("wrap_pc", PC, 32'h0000_0000);
    cycle(1'b0, 1'b0, 32'h0);

    // asynchronous reset in the middle of a flush window
    cycle(1'b0, 1'b1, 32'h0000_0300);
    PCSrc = 1'b0;
    #2;
    Rst = 1'b0;
    #1;
    model_reset();
    check_val("async_flush", 32'(FlushOut), 32'd0);
    check_all();
    @(negedge Clk);
    Rst = 1'b1;

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      src = ($urandom_range(0, 6) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 1) == 1) tgt = {20'h0_0000, tgt[11:0]};
      cycle(st, src, tgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_stage.md
# pc_fetch_stage

Program-counter register and IF/ID pipeline register for the five-stage MIPS datapath. It sits directly downstream of the branch/jump resolution logic. It consumes that logic's `PCSrc`/`PCNew` redirect pair and otherwise advances the PC by 4 each cycle. It latches the fetched instruction into IF/ID and generates squash and stall behaviour for wrong-path and hazard cycles.

## Interface

**Parameters**
- `RESET_PC`, default 32'h00000000: PC value loaded on reset.
- `TRAP_VECTOR`, default 32'h00000080: PC loaded on a misaligned redirect (only when the macro is defined).
- `FLUSH_SLOTS`, default 2: cycles `FlushOut` stays high after an accepted redirect (1–7).

**Ports**
- `Clk`, in, 1: single clock, rising edge.
- `Rst`, in, 1: asynchronous, active-low reset.
- `Stall`, in, 1: hazard-unit hold request.
- `PCSrc`, in, 1: redirect request from branch resolution.
- `PCNew`, in, 32: redirect target.
- `Instruction`, in, 32: instruction memory read data, combinational on `PC`.
- `PC`, out, 32: current fetch address.
- `PCPlus4`, out, 32: `PC`+4, combinational.
- `IFID_Instruction`, out, 32: registered instruction.
- `IFID_PCPlus4`, out, 32: registered `PC`+4.
- `IFID_Valid`, out, 1: IF/ID holds a real instruction.
- `FlushOut`, out, 1: squash wrong-path entries in ID/EX.
- `Misalign`, out, 1: sticky misaligned-redirect flag.

## Operation

- The FSM has three states:
  - **RUN**: normal sequential fetch.
  - **FLUSH**: counting squash cycles after a redirect.
  - **TRAP**: entered after a misaligned redirect; behaves as RUN but keeps `Misalign` set.
- PC next-value priority, highest first:
  1. Reset.
  2. `PCSrc`=1: PC <= `PCNew`. A redirect overrides `Stall`.
  3. `Stall`=1: PC holds.
  4. Otherwise: PC <= PC+4.
- IF/ID update:
  - On a redirect, `IFID_Valid` <= 0 and `IFID_Instruction` <= 32'h00000000 (nop). This squashes the instruction fetched in the redirect cycle.
  - On a stall with no redirect, all IF/ID fields hold.
  - Otherwise, IF/ID <= {`Instruction`, PC+4} and `IFID_Valid` <= 1.
- Flush counter (3 bits):
  - Loaded with `FLUSH_SLOTS` on an accepted redirect; state moves to FLUSH.
  - Decrements every cycle while nonzero, including stall cycles.
  - State returns to RUN (or TRAP) when the counter reaches 0.
  - `FlushOut` = (counter ≠ 0).
- A redirect while in FLUSH reloads the counter to `FLUSH_SLOTS`. The new target wins and no merge occurs.
- Arithmetic: PC+4 is a 32-bit add; overflow wraps from 32'hFFFFFFFC to 32'h00000000 with no flag.

## Timing

- Reset (`Rst`=0, asynchronous) sets:
  - `PC` = `RESET_PC`
  - `IFID_Instruction` = 0
  - `IFID_PCPlus4` = 0
  - `IFID_Valid` = 0
  - counter = 0, `FlushOut` = 0, `Misalign` = 0
  - state = RUN
- The first valid IF/ID entry appears one edge after `Rst` deasserts.
- Redirect latency: when `PCSrc` is sampled high at edge N, `PC` = target after edge N. `FlushOut` is high for edges N+1 through N+`FLUSH_SLOTS`.
- `Stall` is sampled per edge and has no handshake. Holding `Stall` high indefinitely freezes `PC` and IF/ID.
- Reset asserted mid-FLUSH clears the counter immediately, without waiting for an edge.

## Configuration

- **`PC_MISALIGN_TRAP_EN` defined**:
  - A redirect with `PCNew[1:0]` ≠ 0 loads `TRAP_VECTOR` instead of `PCNew`.
  - It sets `Misalign` (sticky until reset), enters TRAP after FLUSH, and otherwise flushes like a normal redirect.
- **`PC_MISALIGN_TRAP_EN` not defined**:
  - `PCNew[1:0]` are forced to 00 on load.
  - `Misalign` is tied to 0.
  - The TRAP state is not built.

## Structure

- A shared package `fetch_pkg` holds:
  - the FSM state encoding (RUN/FLUSH/TRAP),
  - the nop constant 32'h00000000,
  - the PC increment constant 4.
- One sub-module is natural: `ifid_reg`, the IF/ID register with hold (`Stall`) and clear (redirect) controls.

## Test plan

- **Reset**: release `Rst` with `RESET_PC`=0. Expect `PC` to read 0, 4, 8 on successive edges, and `IFID_Valid`=1 from the first edge.
- **Stall**: hold `Stall` for 3 cycles at `PC`=32'h10. Expect `PC` and IF/ID to hold for 3 edges, then `PC` to resume at 32'h14.
- **Redirect**: `PCSrc`=1 with `PCNew`=32'h40 at `PC`=32'h0C. Expect:
  - `PC`=32'h40 on the next edge,
  - `IFID_Valid`=0 for that edge,
  - `FlushOut` high for exactly 2 cycles.
- **Redirect and stall together**: `PCSrc`=1, `PCNew`=32'h80, `Stall`=1 in the same cycle. Expect `PC`=32'h80 (redirect wins) and IF/ID squashed.
- **Back-to-back redirects**: a second redirect to 32'h200 one cycle after a redirect to 32'h100. Expect `PC`=32'h200 and `FlushOut` extended to 2 cycles after the second redirect.
- **Misaligned redirect** (`PC_MISALIGN_TRAP_EN` defined): `PCNew`=32'h43. Expect `PC`=`TRAP_VECTOR` (32'h80) and `Misalign`=1 until reset. With the macro undefined, expect `PC`=32'h40.
